// File: rtl/slave_pkg.sv
// Shared types and constants for the SRAM slave wrapper.
//   state_t       : wrapper FSM states
//   SRAM_AW       : SRAM word-address width
//   DEF_BASE_ADDR : default byte base of the 64 KiB window
//   DEF_RDATA     : default read data for out-of-window reads
//   byte_mask()   : expands a 4-bit active-high byte mask to 32 bits
package slave_pkg;

  localparam int unsigned SRAM_AW = 14;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0001_0000;
  localparam logic [31:0] DEF_RDATA     = 32'hDEAD_BEEF;
  localparam logic [3:0]  WE_NONE       = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/slave_wrapper_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
//   clk, rst : clock, async active-high reset (clears to 0)
//   i_en     : increment request
//   o_cnt    : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/slave_wrapper.sv
// Bus-to-SRAM slave for a 64 KiB window with speculative reads and
// read/write forwarding when both land in the same transfer.
//   clk, rst        : clock, async active-high reset
//   HADDR/HREAD     : bus byte address, read data-phase strobe
//   HWRITE/HWDATA   : active-low byte write enables, write data
//   HRDATA          : read data (0 when HREAD low)
//   CS/OE/WEB/A/DI  : SRAM control, word address and write data
//   DO              : SRAM read data (one-cycle latency)
//   RD_CNT/WR_CNT   : saturating in-window read/write transfer counts
module slave_wrapper
  import slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [31:0] DEFAULT_RDATA = DEF_RDATA
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        HADDR,
  input  logic               HREAD,
  input  logic [BE_W-1:0]    HWRITE,
  input  logic [DATA_W-1:0]  HWDATA,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               CS,
  output logic               OE,
  output logic [BE_W-1:0]    WEB,
  output logic [SRAM_AW-1:0] A,
  output logic [DATA_W-1:0]  DI,
  input  logic [DATA_W-1:0]  DO,
  output logic [CNT_W-1:0]   RD_CNT,
  output logic [CNT_W-1:0]   WR_CNT
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_hit;
  logic                r_whit;
  logic                r_prev_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_wmask;

  logic                w_hit;
  logic                w_wr_req;
  logic                w_cs;
  logic                w_oe;
  logic [BE_W-1:0]     w_web;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_rd_en;
  logic                w_wr_en;
  logic                w_unused;

  // Byte offset and low base bits do not take part in decode.
  assign w_unused = ^{HADDR[1:0], BASE_ADDR[15:0]};

  assign w_hit    = (HADDR[31:16] == BASE_ADDR[31:16]);
  assign w_wr_req = (HWRITE != WE_NONE);

  // State and write-capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hit     <= 1'b0;
      r_whit    <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_prev_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hit     <= w_hit;
      r_prev_wr <= (r_state == ST_IDLE) && w_wr_req;
      if ((r_state == ST_IDLE) && w_wr_req) begin
        r_wdata <= HWDATA & byte_mask(~HWRITE);
        r_wmask <= ~HWRITE;
        r_whit  <= w_hit;
      end
    end
  end

  // Next state and SRAM strobes; the write is issued in IDLE, WDATA only
  // retires the transfer so the held bus write is not performed twice.
  always_comb begin
    w_state_nxt = r_state;
    w_cs        = 1'b0;
    w_oe        = 1'b0;
    w_web       = WE_NONE;
    case (r_state)
      ST_IDLE: begin
        w_cs  = w_hit;
        w_oe  = w_hit;
        w_web = w_hit ? HWRITE : WE_NONE;
        if (w_wr_req) begin
          w_state_nxt = ST_WDATA;
        end
      end
      ST_WDATA: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (rst) begin
      w_cs  = 1'b0;
      w_oe  = 1'b0;
      w_web = WE_NONE;
    end
  end

  // Read mux; in WDATA the captured write is forwarded instead of DO.
  always_comb begin
    w_rdata = '0;
    if (!rst && HREAD) begin
      if (r_state == ST_WDATA) begin
        w_rdata = r_whit ? (r_wdata & byte_mask(r_wmask)) : DEFAULT_RDATA;
      end else begin
        w_rdata = r_hit ? DO : DEFAULT_RDATA;
      end
    end
  end

  assign w_rd_en = HREAD && ((r_state == ST_WDATA) ? r_whit : r_hit);
  assign w_wr_en = (r_state == ST_WDATA) && r_whit && r_prev_wr;

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_rd_en),
    .o_cnt (RD_CNT)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_wr_en),
    .o_cnt (WR_CNT)
  );

  assign CS     = w_cs;
  assign OE     = w_oe;
  assign WEB    = w_web;
  assign A      = HADDR[SRAM_AW+1:2];
  assign DI     = HWDATA;
  assign HRDATA = w_rdata;

endmodule
